// File: rtl/prod_accum_stage_pkg.sv
// Shared types and helpers for the product accumulator stage.
//   state_t  : accumulator FSM states (ACC collecting terms, HOLD presenting a result)
//   *_DEF    : default widths / term count
//   sat_add  : width-generic saturating unsigned add, returns {ovf, sum}
package prod_accum_stage_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned PW_DEF      = 8;
    localparam int unsigned N_TERMS_DEF = 4;
    localparam int unsigned ACC_W_DEF   = 10;
    localparam int unsigned SAT_MAX_W   = 32;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] sum;
    } sat_res_t;

    // Operands are expected to fit in w bits (w <= SAT_MAX_W); the sum is
    // formed one bit wider and clamped to 2^w-1 when it spills past w bits.
    function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                         input logic [SAT_MAX_W-1:0] b,
                                         input int unsigned          w);
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] lim;
        sat_res_t           r;
        full  = {1'b0, a} + {1'b0, b};
        lim   = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        r.ovf = (full > lim);
        r.sum = r.ovf ? lim[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/prod_accum_stage.sv
// Multiply-accumulate back end: sums N_TERMS unsigned products into one
// saturating dot-product result and presents it on a valid/ready port.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   clear            : synchronous abort; drops partial sum and any held result
//   p_valid/p_ready  : product handshake (p_ready decoded from state and clear)
//   p_data           : unsigned product, PW bits
//   sum_valid/ready  : result handshake
//   sum_data         : accumulated result, ACC_W bits, saturated
//   sum_ovf          : result was saturated (qualified by sum_valid)
//   busy             : at least one term taken and result not yet delivered
module prod_accum_stage
    import prod_accum_stage_pkg::*;
#(
    parameter int unsigned PW      = PW_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned CW      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [PW-1:0]    p_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum_data,
    output logic             sum_ovf,
    output logic             busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    sat_res_t         add;
    logic             take;
    logic             last_term;

    // Products are only taken while collecting, and never in a clear cycle.
    assign p_ready   = (state == ACC) && !clear;
    assign take      = p_valid && p_ready;
    assign last_term = (cnt == CW'(N_TERMS - 1));

    always_comb add = sat_add(32'(acc), 32'(p_data), ACC_W);

    // Accumulator FSM with registered result port; reset beats clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
            sum_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (take) begin
                        busy <= 1'b1;
                        if (last_term) begin
                            // Final term goes straight to the output register.
                            sum_data  <= ACC_W'(add.sum);
                            sum_ovf   <= ovf | add.ovf;
                            sum_valid <= 1'b1;
                            state     <= HOLD;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= ACC_W'(add.sum);
                            ovf <= ovf | add.ovf;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        busy      <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum_stage.sv
// Scoreboard bench for prod_accum_stage: three configurations (default,
// ACC_W=9, N_TERMS=1) run the same directed and random stimulus in parallel.
module tb_prod_accum_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input int id, input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL i%0d %s: got %0d expected %0d", id, nm, act, exp);
        end
    endtask

    task automatic fail(input int id, input string nm, input longint act);
        checks++;
        errors++;
        $display("FAIL i%0d %s: got %0d", id, nm, act);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned NT  = (g == 2) ? 1 : 4;
        localparam int unsigned AW  = (g == 1) ? 9 : 10;
        localparam int unsigned CWI = (NT > 1) ? $clog2(NT) : 1;

        typedef struct {
            int d;
            bit o;
        } exp_t;

        logic          rst_n = 1'b0;
        logic          clear = 1'b0;
        logic          p_valid = 1'b0;
        logic [7:0]    p_data = '0;
        logic          sum_ready = 1'b0;
        logic          p_ready;
        logic          sum_valid;
        logic [AW-1:0] sum_data;
        logic          sum_ovf;
        logic          busy;

        exp_t expq[$];
        int   n_in = 0;
        int   tot = 0;
        int   sr_mode = 0;  // 0: never ready, 1: always, 2: after 5 held cycles, 3: random
        int   hc = 0;
        bit   fin = 0;

        prod_accum_stage #(
            .PW(8), .N_TERMS(NT), .ACC_W(AW), .CW(CWI)
        ) dut (
            .clk(clk), .rst_n(rst_n), .clear(clear),
            .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
            .sum_valid(sum_valid), .sum_ready(sum_ready),
            .sum_data(sum_data), .sum_ovf(sum_ovf), .busy(busy)
        );

        // Downstream ready generator.
        always @(posedge clk) begin
            #2;
            if (sum_valid) hc++;
            else hc = 0;
            case (sr_mode)
                0:       sum_ready = 1'b0;
                1:       sum_ready = 1'b1;
                2:       sum_ready = (hc > 5);
                default: sum_ready = 1'($urandom_range(0, 1));
            endcase
        end

        // Monitor: checks every accepted result against the queue, plus port invariants.
        bit            prev_held = 0;
        bit            prev_accept = 0;
        logic [AW-1:0] prev_data = '0;
        logic          prev_ovf = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                prev_held   = 0;
                prev_accept = 0;
            end else begin
                chk(g, "p_ready vs state", p_ready, (!sum_valid && !clear));
                if (prev_accept) chk(g, "sum_valid after accept", sum_valid, 0);
                if (prev_held && sum_valid) begin
                    chk(g, "held sum_data stable", sum_data, prev_data);
                    chk(g, "held sum_ovf stable", sum_ovf, prev_ovf);
                end
                prev_accept = 0;
                prev_held   = sum_valid && !sum_ready && !clear;
                prev_data   = sum_data;
                prev_ovf    = sum_ovf;
                if (sum_valid && sum_ready && !clear) begin
                    if (expq.size() == 0) begin
                        fail(g, "unexpected result", sum_data);
                    end else begin
                        e = expq.pop_front();
                        chk(g, "sum_data", sum_data, e.d);
                        chk(g, "sum_ovf", sum_ovf, e.o);
                    end
                    prev_accept = 1;
                end
            end
        end

        // Offer one product after a gap; reference model updates on handshake.
        task automatic send(input int v, input int gap);
            int   waits;
            bit   ok;
            bit   last;
            int   maxv;
            exp_t e;
            waits = 0;
            ok    = 0;
            last  = 0;
            p_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            p_valid = 1'b1;
            p_data  = 8'(v);
            while (!ok && waits <= 200) begin
                @(negedge clk);
                if (p_ready) ok = 1;
                else begin
                    waits++;
                    @(posedge clk); #1;
                end
            end
            if (!ok) begin
                fail(g, "p_ready wait timeout", waits);
                p_valid = 1'b0;
                return;
            end
            tot += v;
            n_in++;
            if (n_in == NT) begin
                maxv = (1 << AW) - 1;
                e.d  = (tot > maxv) ? maxv : tot;
                e.o  = (tot > maxv);
                expq.push_back(e);
                n_in = 0;
                tot  = 0;
                last = 1;
            end
            @(posedge clk); #1;
            p_valid = 1'b0;
            if (last) begin
                @(negedge clk);
                chk(g, "latency sum_valid", sum_valid, 1);
                chk(g, "hold p_ready", p_ready, 0);
                chk(g, "hold busy", busy, 1);
                @(posedge clk); #1;
                if (sr_mode == 1) begin
                    @(negedge clk);
                    chk(g, "p_ready back after accept", p_ready, 1);
                    @(posedge clk); #1;
                end
            end
        endtask

        task automatic drain_idle();
            int k;
            k = 0;
            while (expq.size() != 0 && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (expq.size() != 0) fail(g, "drain timeout", expq.size());
            @(posedge clk); #1;
            @(negedge clk);
            chk(g, "idle sum_valid", sum_valid, 0);
            chk(g, "idle busy", busy, (n_in > 0));
            @(posedge clk); #1;
        endtask

        task automatic do_clear(input int v);
            clear   = 1'b1;
            p_valid = 1'b1;
            p_data  = 8'(v);
            @(negedge clk);
            chk(g, "p_ready during clear", p_ready, 0);
            @(posedge clk); #1;
            clear   = 1'b0;
            p_valid = 1'b0;
            expq.delete();
            n_in = 0;
            tot  = 0;
            @(negedge clk);
            chk(g, "busy after clear", busy, 0);
            chk(g, "sum_valid after clear", sum_valid, 0);
            @(posedge clk); #1;
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            expq.delete();
            n_in = 0;
            tot  = 0;
            @(negedge clk);
            chk(g, "reset sum_valid", sum_valid, 0);
            chk(g, "reset sum_data", sum_data, 0);
            chk(g, "reset sum_ovf", sum_ovf, 0);
            chk(g, "reset busy", busy, 0);
            chk(g, "reset p_ready", p_ready, 1);
            @(posedge clk); #1;
        endtask

        initial begin
            repeat (2) @(posedge clk);
            #1;
            do_reset();

            sr_mode = 1;
            repeat (4) send(225, 0);
            send(1, 0); send(2, 0); send(3, 0); send(4, 0);

            sr_mode = 2;
            send(6, 2); send(0, 2); send(9, 2); send(15, 2);
            drain_idle();

            sr_mode = 1;
            send(100, 0); send(50, 0);
            drain_idle();
            do_clear(77);
            repeat (4) send(1, 0);
            drain_idle();

            sr_mode = 0;
            for (int i = 0; i < NT; i++) send(225, 0);
            repeat (2) begin @(posedge clk); #1; end
            @(negedge clk);
            chk(g, "held before reset valid", sum_valid, 1);
            if (expq.size() != 0) chk(g, "held before reset data", sum_data, expq[0].d);
            @(posedge clk); #1;
            do_reset();

            sr_mode = 1;
            repeat (4) send(10, 0);
            send(3, 0); send(5, 0); send(7, 0);

            sr_mode = 3;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 15) == 0) do_clear($urandom_range(0, 255));
                send($urandom_range(0, 255), $urandom_range(0, 2));
            end
            drain_idle();
            fin = 1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) fail(-1, "global timeout", k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
